// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle between the ALU sequencer and the serial subtractor.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored while the subtractor is occupied.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;
    logic             zero;

    // Sequencer side: issues operations, collects results.
    modport master (
        output start, a, b, b_in,
        input  busy, done, diff, b_out, ovf, zero
    );

    // Subtractor side.
    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff, b_out, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Serial a - b - b_in, two bits per clock LSB first, borrow chained between steps.
// Latency: done pulses WIDTH/2 + 1 cycles after the accepting edge; results held until next done.
// Backpressure: start accepted only in IDLE; start during BUSY/DONE is dropped, never queued.
module serial_subtractor #(
    parameter int WIDTH = 8   // must be even and >= 2
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int STEPS = WIDTH / 2;
    localparam int CW    = (STEPS < 2) ? 1 : $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_d_sh;
    logic             r_brw;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_b_out;
    logic             r_ovf;
    logic             r_zero;

    logic [2:0]       w_step;
    logic [WIDTH-1:0] w_d_next;

    // One 2-bit subtract step; bit 2 of the wrapped 3-bit result is the borrow.
    always_comb begin
        w_step = {1'b0, r_a_sh[1:0]} - {1'b0, r_b_sh[1:0]} - {2'b00, r_brw};
    end

    // New digit enters at the top so after STEPS shifts the LSB pair sits at bit 0.
    generate
        if (WIDTH == 2) begin : g_narrow
            assign w_d_next = w_step[1:0];
        end else begin : g_wide
            assign w_d_next = {w_step[1:0], r_d_sh[WIDTH-1:2]};
        end
    endgenerate

    // Control FSM plus datapath; result registers only move on the DONE-entry edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_d_sh  <= '0;
            r_brw   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_b_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_brw   <= bus.b_in;
                        r_d_sh  <= '0;
                        // Sign bits kept aside: the shift registers lose them during the run.
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.b[WIDTH-1];
                        r_count <= CW'(STEPS);
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_a_sh  <= r_a_sh >> 2;
                    r_b_sh  <= r_b_sh >> 2;
                    r_d_sh  <= w_d_next;
                    r_brw   <= w_step[2];
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                        r_diff  <= w_d_next;
                        r_b_out <= w_step[2];
                        r_ovf   <= (r_a_msb != r_b_msb) && (w_d_next[WIDTH-1] != r_a_msb);
                        r_zero  <= (w_d_next == '0);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.diff  = r_diff;
    assign bus.b_out = r_b_out;
    assign bus.ovf   = r_ovf;
    assign bus.zero  = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with hand-computed expectations.
// Latency: checks busy in cycles 1-4 and done in cycle 5 after each accepted start.
// Backpressure: exercises start re-pulse during BUSY, start held high, and mid-run reset.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_ops(input logic [7:0] av, input logic [7:0] bv, input logic bin);
        bus.a    = av;
        bus.b    = bv;
        bus.b_in = bin;
    endtask

    // Runs n cycles from the current cycle (called just after a rising edge), driving
    // start from start_m; at cycle chg the operands are scrambled. Records done/busy per cycle.
    task automatic window(input int n, input logic [31:0] start_m, input int chg,
                          output logic [31:0] done_m, output logic [31:0] busy_m);
        done_m = '0;
        busy_m = '0;
        for (int i = 0; i < n; i++) begin
            bus.start = start_m[i];
            if (i == chg) set_ops(8'hAA, 8'h11, 1'b1);
            @(negedge clk);
            done_m[i] = bus.done;
            busy_m[i] = bus.busy;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [7:0] ed, input logic eb,
                             input logic eo, input logic ez);
        @(negedge clk);
        check_eq({tag, "_diff"}, {24'h0, bus.diff}, {24'h0, ed});
        check_eq({tag, "_bout"}, {31'h0, bus.b_out}, {31'h0, eb});
        check_eq({tag, "_ovf"},  {31'h0, bus.ovf},  {31'h0, eo});
        check_eq({tag, "_zero"}, {31'h0, bus.zero}, {31'h0, ez});
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic bin, input logic [7:0] ed, input logic eb,
                          input logic eo, input logic ez);
        logic [31:0] dm, bm;
        set_ops(av, bv, bin);
        window(7, 32'h1, -1, dm, bm);
        check_eq({tag, "_done_cyc"}, dm, 32'h20);
        check_eq({tag, "_busy_cyc"}, bm, 32'h1E);
        check_res(tag, ed, eb, eo, ez);
    endtask

    initial begin
        logic [31:0] dm, bm;
        bus.start = 1'b0;
        set_ops(8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_busy", {31'h0, bus.busy}, 32'h0);
        check_eq("rst_done", {31'h0, bus.done}, 32'h0);
        check_eq("rst_diff", {24'h0, bus.diff}, 32'h0);
        check_eq("rst_flags", {29'h0, bus.b_out, bus.ovf, bus.zero}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op("sub_5_3",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        run_op("sub_3_5",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        run_op("ovf_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("ovf_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        run_op("zero_bin",  8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        run_op("wrap_bin",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Start re-pulsed in cycle 2 with new operands: ignored, original result kept.
        set_ops(8'h40, 8'h21, 1'b0);
        window(9, 32'h5, 2, dm, bm);
        check_eq("repulse_done_cyc", dm, 32'h20);
        check_eq("repulse_busy_cyc", bm, 32'h1E);
        check_res("repulse", 8'h1F, 1'b0, 1'b0, 1'b0);

        // Start held high for 12 cycles: back-to-back ops every 6 cycles.
        set_ops(8'h09, 8'h04, 1'b0);
        window(14, 32'hFFF, -1, dm, bm);
        check_eq("hold_done_cyc", dm, 32'h820);
        check_eq("hold_busy_cyc", bm, 32'h79E);
        check_res("hold", 8'h05, 1'b0, 1'b0, 1'b0);

        // Leave nonzero result and flags, then reset in cycle 3 of the next run.
        run_op("pre_rst", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        set_ops(8'h05, 8'h03, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;      // cycle 1
        bus.start = 1'b0;
        @(posedge clk); #1;      // cycle 2
        @(posedge clk); #1;      // cycle 3
        rst = 1'b1;
        @(posedge clk); #1;      // cycle 4
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", {31'h0, bus.busy}, 32'h0);
        check_eq("midrst_done", {31'h0, bus.done}, 32'h0);
        check_eq("midrst_diff", {24'h0, bus.diff}, 32'h0);
        check_eq("midrst_flags", {29'h0, bus.b_out, bus.ovf, bus.zero}, 32'h0);
        @(posedge clk); #1;
        window(7, 32'h0, -1, dm, bm);
        check_eq("midrst_no_done", dm, 32'h0);
        check_eq("midrst_no_busy", bm, 32'h0);
        run_op("post_rst", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
